// File: rtl/directory_req_sched.sv
// Directory bank input scheduler: demand and prefetch FIFOs arbitrated onto one
// valid/retry port, demand-first with a prefetch starvation bound.
module directory_req_sched #(
    parameter int REQ_DEPTH = 8,
    parameter int PF_DEPTH  = 8,
    parameter int REQ_W     = 64,
    parameter int PF_W      = 48,
    parameter int PF_STARVE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l2todr_req_valid,
    output logic             l2todr_req_retry,
    input  logic [REQ_W-1:0] l2todr_req,
    input  logic             l2todr_pfreq_valid,
    output logic             l2todr_pfreq_retry,
    input  logic [PF_W-1:0]  l2todr_pfreq,
    output logic             sched_valid,
    input  logic             sched_retry,
    output logic             sched_is_pf,
    output logic [REQ_W-1:0] sched_req,
    output logic [PF_W-1:0]  sched_pfreq,
    output logic             pf_drop,
    output logic [15:0]      pf_drop_cnt
);
    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int PAW = $clog2(PF_DEPTH);
    localparam int PCW = PAW + 1;
    localparam int SW  = $clog2(PF_STARVE + 1);
    localparam logic [RCW-1:0] REQ_FULL_CNT = RCW'(REQ_DEPTH);
    localparam logic [PCW-1:0] PF_FULL_CNT  = PCW'(PF_DEPTH);
    localparam logic [SW-1:0]  STARVE_MAX   = SW'(PF_STARVE);

    logic [REQ_W-1:0] req_mem [REQ_DEPTH];
    logic [RAW-1:0]   req_rd, req_wr;
    logic [RCW-1:0]   req_cnt, req_cnt_nxt;
    logic             req_full, req_empty;

    logic [PF_W-1:0]  pf_mem [PF_DEPTH];
    logic [PAW-1:0]   pf_rd, pf_wr;
    logic [PCW-1:0]   pf_cnt, pf_cnt_nxt;
    logic             pf_full, pf_empty;

    logic             lock, lock_is_pf;
    logic [SW-1:0]    starve_cnt, starve_nxt;
    logic             sel_pf, grant, req_deq, pf_deq, req_enq;
    logic             pf_head_held, pf_drop_in, pf_drop_old, pf_wr_en, pf_rd_adv;

    assign l2todr_req_retry   = req_full;
    assign l2todr_pfreq_retry = 1'b0;
    assign req_empty          = (req_cnt == '0);
    assign pf_empty           = (pf_cnt == '0);

    always_comb begin
        sel_pf = 1'b0;
        if (lock)
            sel_pf = lock_is_pf;
        else
            sel_pf = !pf_empty && (req_empty || starve_cnt == STARVE_MAX);
    end

    assign sched_valid = lock | !req_empty | !pf_empty;
    assign sched_is_pf = sel_pf;
    assign sched_req   = req_mem[req_rd];
    assign sched_pfreq = pf_mem[pf_rd];

    assign grant   = sched_valid & !sched_retry;
    assign req_deq = grant & !sel_pf;
    assign pf_deq  = grant & sel_pf;
    assign req_enq = l2todr_req_valid & !req_full;

    // A presented-and-retried prefetch head must stay put, so a full queue
    // sacrifices the incoming entry; otherwise the oldest entry is evicted.
    assign pf_head_held = sel_pf & sched_retry;
    assign pf_drop_in   = l2todr_pfreq_valid & pf_full & !pf_deq & pf_head_held;
    assign pf_drop_old  = l2todr_pfreq_valid & pf_full & !pf_deq & !pf_head_held;
    assign pf_wr_en     = l2todr_pfreq_valid & !pf_drop_in;
    assign pf_rd_adv    = pf_deq | pf_drop_old;

    assign req_cnt_nxt = req_cnt + RCW'(req_enq) - RCW'(req_deq);
    assign pf_cnt_nxt  = pf_cnt + PCW'(pf_wr_en) - PCW'(pf_rd_adv);

    always_comb begin
        starve_nxt = starve_cnt;
        if (pf_deq || pf_empty)
            starve_nxt = '0;
        else if (req_deq && starve_cnt != STARVE_MAX)
            starve_nxt = starve_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_rd      <= '0;
            req_wr      <= '0;
            req_cnt     <= '0;
            req_full    <= 1'b0;
            pf_rd       <= '0;
            pf_wr       <= '0;
            pf_cnt      <= '0;
            pf_full     <= 1'b0;
            lock        <= 1'b0;
            lock_is_pf  <= 1'b0;
            starve_cnt  <= '0;
            pf_drop     <= 1'b0;
            pf_drop_cnt <= '0;
        end else begin
            if (req_enq)   req_wr <= req_wr + RAW'(1);
            if (req_deq)   req_rd <= req_rd + RAW'(1);
            if (pf_wr_en)  pf_wr  <= pf_wr + PAW'(1);
            if (pf_rd_adv) pf_rd  <= pf_rd + PAW'(1);
            req_cnt    <= req_cnt_nxt;
            req_full   <= (req_cnt_nxt == REQ_FULL_CNT);
            pf_cnt     <= pf_cnt_nxt;
            pf_full    <= (pf_cnt_nxt == PF_FULL_CNT);
            lock       <= sched_valid & sched_retry;
            lock_is_pf <= sel_pf;
            starve_cnt <= starve_nxt;
            pf_drop    <= pf_drop_in | pf_drop_old;
            if ((pf_drop_in || pf_drop_old) && pf_drop_cnt != 16'hFFFF)
                pf_drop_cnt <= pf_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (req_enq)  req_mem[req_wr] <= l2todr_req;
        if (pf_wr_en) pf_mem[pf_wr]   <= l2todr_pfreq;
    end
endmodule

// File: tb/tb_directory_req_sched.sv
// Self-checking bench for directory_req_sched: directed scenarios plus a random
// run against a queue-based reference model.
module tb_directory_req_sched;
    localparam int REQ_DEPTH = 16;
    localparam int PF_DEPTH  = 4;
    localparam int REQ_W     = 64;
    localparam int PF_W      = 48;
    localparam int PF_STARVE = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             l2todr_req_valid = 1'b0;
    logic             l2todr_req_retry;
    logic [REQ_W-1:0] l2todr_req = '0;
    logic             l2todr_pfreq_valid = 1'b0;
    logic             l2todr_pfreq_retry;
    logic [PF_W-1:0]  l2todr_pfreq = '0;
    logic             sched_valid;
    logic             sched_retry = 1'b0;
    logic             sched_is_pf;
    logic [REQ_W-1:0] sched_req;
    logic [PF_W-1:0]  sched_pfreq;
    logic             pf_drop;
    logic [15:0]      pf_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [REQ_W-1:0] rq[$];
    logic [PF_W-1:0]  pq[$];
    bit m_lock, m_lock_pf, m_drop;
    int m_starve, m_drop_cnt;

    directory_req_sched #(
        .REQ_DEPTH(REQ_DEPTH), .PF_DEPTH(PF_DEPTH), .REQ_W(REQ_W),
        .PF_W(PF_W), .PF_STARVE(PF_STARVE)
    ) dut (
        .clk(clk), .reset(reset),
        .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry),
        .l2todr_req(l2todr_req),
        .l2todr_pfreq_valid(l2todr_pfreq_valid), .l2todr_pfreq_retry(l2todr_pfreq_retry),
        .l2todr_pfreq(l2todr_pfreq),
        .sched_valid(sched_valid), .sched_retry(sched_retry), .sched_is_pf(sched_is_pf),
        .sched_req(sched_req), .sched_pfreq(sched_pfreq),
        .pf_drop(pf_drop), .pf_drop_cnt(pf_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] dv(input int i);
        return 64'hD1D1_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [PF_W-1:0] pv(input int i);
        return 48'hBEEF_0000_0000 | 48'(i);
    endfunction

    function automatic bit m_valid();
        return m_lock || rq.size() != 0 || pq.size() != 0;
    endfunction

    function automatic bit m_is_pf();
        if (m_lock) return m_lock_pf;
        return pq.size() != 0 && (rq.size() == 0 || m_starve == PF_STARVE);
    endfunction

    task automatic model_clear();
        rq.delete();
        pq.delete();
        m_lock = 0; m_lock_pf = 0; m_drop = 0; m_starve = 0; m_drop_cnt = 0;
    endtask

    // Applies one cycle of inputs (called at a negedge) and advances the model.
    task automatic drive(input bit rv, input logic [REQ_W-1:0] rd,
                         input bit pvld, input logic [PF_W-1:0] pd, input bit sr);
        bit valid, is_pf, grant, pf_full, pf_was_empty, req_acc;
        l2todr_req_valid = rv;  l2todr_req = rd;
        l2todr_pfreq_valid = pvld; l2todr_pfreq = pd;
        sched_retry = sr;
        valid = m_valid();
        is_pf = m_is_pf();
        grant = valid && !sr;
        pf_full = (pq.size() == PF_DEPTH);
        pf_was_empty = (pq.size() == 0);
        req_acc = rv && (rq.size() != REQ_DEPTH);
        @(posedge clk);
        m_drop = 0;
        if (grant) begin
            if (is_pf) void'(pq.pop_front());
            else       void'(rq.pop_front());
        end
        if ((grant && is_pf) || pf_was_empty) m_starve = 0;
        else if (grant && m_starve < PF_STARVE) m_starve++;
        if (pvld) begin
            if (!pf_full || (grant && is_pf)) pq.push_back(pd);
            else begin
                if (!(valid && is_pf && sr)) begin
                    void'(pq.pop_front());
                    pq.push_back(pd);
                end
                m_drop = 1;
                if (m_drop_cnt < 65535) m_drop_cnt++;
            end
        end
        if (req_acc) rq.push_back(rd);
        m_lock = valid && sr;
        m_lock_pf = is_pf;
        @(negedge clk);
    endtask

    task automatic idle(input bit sr);
        drive(1'b0, '0, 1'b0, '0, sr);
    endtask

    task automatic reset_dut();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        l2todr_req_valid = 0; l2todr_pfreq_valid = 0; sched_retry = 0;
        reset = 1'b0;
        model_clear();
        #3;
        n_tests++; if (l2todr_req_retry !== 1'b0) begin n_fail++; $display("FAIL reset_req_retry: got %b want 0", l2todr_req_retry); end
        n_tests++; if (l2todr_pfreq_retry !== 1'b0) begin n_fail++; $display("FAIL reset_pf_retry: got %b want 0", l2todr_pfreq_retry); end
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sched_valid); end
        n_tests++; if (sched_is_pf !== 1'b0) begin n_fail++; $display("FAIL reset_is_pf: got %b want 0", sched_is_pf); end
        n_tests++; if (pf_drop !== 1'b0) begin n_fail++; $display("FAIL reset_pf_drop: got %b want 0", pf_drop); end
        n_tests++; if (pf_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", pf_drop_cnt); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        reset_dut();
        drive(1'b1, dv(7), 1'b0, '0, 1'b0);
        n_tests++; if (sched_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", sched_valid); end
        n_tests++; if (sched_is_pf !== 1'b0) begin n_fail++; $display("FAIL single_is_pf: got %b want 0", sched_is_pf); end
        n_tests++; if (sched_req !== dv(7)) begin n_fail++; $display("FAIL single_payload: got %h want %h", sched_req, dv(7)); end
        idle(1'b0);
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", sched_valid); end
    endtask

    task automatic test_req_full();
        reset_dut();
        for (int i = 0; i < REQ_DEPTH; i++) begin
            n_tests++; if (l2todr_req_retry !== 1'b0) begin n_fail++; $display("FAIL full_early_retry[%0d]: got %b want 0", i, l2todr_req_retry); end
            drive(1'b1, dv(i), 1'b0, '0, 1'b1);
        end
        n_tests++; if (l2todr_req_retry !== 1'b1) begin n_fail++; $display("FAIL full_retry: got %b want 1", l2todr_req_retry); end
        drive(1'b1, dv(100), 1'b0, '0, 1'b1);
        n_tests++; if (sched_req !== dv(0)) begin n_fail++; $display("FAIL full_hold_head: got %h want %h", sched_req, dv(0)); end
        n_tests++; if (l2todr_req_retry !== 1'b1) begin n_fail++; $display("FAIL full_retry_hold: got %b want 1", l2todr_req_retry); end
        // dequeue while full: push still retried this cycle, retry clears next
        drive(1'b1, dv(101), 1'b0, '0, 1'b0);
        n_tests++; if (l2todr_req_retry !== 1'b0) begin n_fail++; $display("FAIL full_retry_clear: got %b want 0", l2todr_req_retry); end
        for (int i = 1; i < REQ_DEPTH; i++) begin
            n_tests++; if (sched_valid !== 1'b1 || sched_is_pf !== 1'b0 || sched_req !== dv(i)) begin
                n_fail++; $display("FAIL full_drain[%0d]: got v=%b pf=%b %h want v=1 pf=0 %h", i, sched_valid, sched_is_pf, sched_req, dv(i));
            end
            idle(1'b0);
        end
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_empty: got %b want 0", sched_valid); end
    endtask

    task automatic test_starve();
        bit exp_pf;
        logic [REQ_W-1:0] exp_d;
        reset_dut();
        for (int i = 0; i < 12; i++) drive(1'b1, dv(i), 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1, pv(50), 1'b1);
        for (int k = 0; k < 13; k++) begin
            exp_pf = (k == 8);
            exp_d = dv(k < 8 ? k : k - 1);
            n_tests++;
            if (sched_valid !== 1'b1 || sched_is_pf !== exp_pf ||
                (exp_pf && sched_pfreq !== pv(50)) || (!exp_pf && sched_req !== exp_d)) begin
                n_fail++;
                $display("FAIL starve_grant[%0d]: got v=%b pf=%b req=%h pfreq=%h want pf=%b req=%h pfreq=%h",
                         k, sched_valid, sched_is_pf, sched_req, sched_pfreq, exp_pf, exp_d, pv(50));
            end
            idle(1'b0);
        end
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL starve_empty: got %b want 0", sched_valid); end
    endtask

    task automatic test_pf_drop_oldest();
        reset_dut();
        drive(1'b1, dv(3), 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1, pv(i), 1'b1);
            n_tests++; if (pf_drop !== (i >= 4)) begin n_fail++; $display("FAIL drop_pulse[%0d]: got %b want %b", i, pf_drop, (i >= 4)); end
        end
        idle(1'b1);
        n_tests++; if (pf_drop !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end: got %b want 0", pf_drop); end
        n_tests++; if (pf_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_cnt: got %0d want 2", pf_drop_cnt); end
        n_tests++; if (sched_is_pf !== 1'b0 || sched_req !== dv(3)) begin n_fail++; $display("FAIL drop_demand_head: got pf=%b %h want pf=0 %h", sched_is_pf, sched_req, dv(3)); end
        idle(1'b0);
        for (int k = 2; k < 6; k++) begin
            n_tests++; if (sched_valid !== 1'b1 || sched_is_pf !== 1'b1 || sched_pfreq !== pv(k)) begin
                n_fail++; $display("FAIL drop_order[%0d]: got v=%b pf=%b %h want %h", k, sched_valid, sched_is_pf, sched_pfreq, pv(k));
            end
            idle(1'b0);
        end
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL drop_empty: got %b want 0", sched_valid); end
    endtask

    task automatic test_pf_locked_drop();
        reset_dut();
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, pv(20 + i), 1'b1);
        drive(1'b0, '0, 1'b1, pv(24), 1'b1);
        n_tests++; if (pf_drop !== 1'b1) begin n_fail++; $display("FAIL lock_drop_pulse: got %b want 1", pf_drop); end
        n_tests++; if (pf_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL lock_drop_cnt: got %0d want 1", pf_drop_cnt); end
        n_tests++; if (sched_is_pf !== 1'b1 || sched_pfreq !== pv(20)) begin n_fail++; $display("FAIL lock_head: got pf=%b %h want pf=1 %h", sched_is_pf, sched_pfreq, pv(20)); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (sched_valid !== 1'b1 || sched_is_pf !== 1'b1 || sched_pfreq !== pv(20 + k)) begin
                n_fail++; $display("FAIL lock_drain[%0d]: got v=%b pf=%b %h want %h", k, sched_valid, sched_is_pf, sched_pfreq, pv(20 + k));
            end
            idle(1'b0);
        end
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL lock_empty: got %b want 0", sched_valid); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        drive(1'b1, dv(40), 1'b1, pv(40), 1'b1);
        drive(1'b1, dv(41), 1'b1, pv(41), 1'b1);
        drive(1'b1, dv(42), 1'b0, '0, 1'b1);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", sched_valid); end
        n_tests++; if (sched_is_pf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_is_pf: got %b want 0", sched_is_pf); end
        n_tests++; if (l2todr_req_retry !== 1'b0) begin n_fail++; $display("FAIL mid_reset_retry: got %b want 0", l2todr_req_retry); end
        @(negedge clk);
        l2todr_req_valid = 0; l2todr_pfreq_valid = 0; sched_retry = 0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            n_tests++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle[%0d]: got %b want 0", k, sched_valid); end
        end
        drive(1'b1, dv(43), 1'b0, '0, 1'b1);
        n_tests++; if (sched_valid !== 1'b1 || sched_req !== dv(43)) begin n_fail++; $display("FAIL mid_reset_new: got v=%b %h want v=1 %h", sched_valid, sched_req, dv(43)); end
    endtask

    task automatic test_random();
        bit rv, pvld, sr, ev, ep;
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            ev = m_valid();
            ep = m_is_pf();
            n_tests++;
            if (sched_valid !== ev || (ev && sched_is_pf !== ep) ||
                (ev && !ep && sched_req !== rq[0]) || (ev && ep && sched_pfreq !== pq[0])) begin
                n_fail++;
                $display("FAIL rand_present[%0d]: got v=%b pf=%b req=%h pfreq=%h want v=%b pf=%b", c, sched_valid, sched_is_pf, sched_req, sched_pfreq, ev, ep);
            end
            n_tests++;
            if (l2todr_req_retry !== (rq.size() == REQ_DEPTH) || l2todr_pfreq_retry !== 1'b0) begin
                n_fail++; $display("FAIL rand_retry[%0d]: got req=%b pf=%b want req=%b pf=0", c, l2todr_req_retry, l2todr_pfreq_retry, rq.size() == REQ_DEPTH);
            end
            n_tests++;
            if (pf_drop !== m_drop || pf_drop_cnt !== 16'(m_drop_cnt)) begin
                n_fail++; $display("FAIL rand_drop[%0d]: got %b/%0d want %b/%0d", c, pf_drop, pf_drop_cnt, m_drop, m_drop_cnt);
            end
            rv   = ($urandom_range(0, 99) < 60);
            pvld = ($urandom_range(0, 99) < 35);
            sr   = ($urandom_range(0, 99) < 40);
            drive(rv, {$urandom, $urandom}, pvld, PF_W'({$urandom, $urandom}), sr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_req_full();
        test_starve();
        test_pf_drop_oldest();
        test_pf_locked_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/directory_req_sched.md
# directory_req_sched

Input scheduler in front of the directory bank pipeline. It holds two pending-request queues: a demand queue fed by `l2todr_req` and a prefetch queue fed by `l2todr_pfreq`. It issues one entry per cycle to the directory tag pipeline over a valid/retry handshake. Demand has priority, with a starvation bound for prefetches; a full prefetch queue drops its oldest entry rather than back-pressuring.

## Interface
Parameters:
- `REQ_DEPTH`, default 8: demand queue entries; legal values 4, 8, 16.
- `PF_DEPTH`, default 8: prefetch queue entries; legal values 4, 8, 16.
- `REQ_W`, default 64: width of a packed `I_l2todr_req_type`.
- `PF_W`, default 48: width of a packed `I_l2todr_pfreq_type`.
- `PF_STARVE`, default 8: maximum consecutive demand grants while a prefetch is pending.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `l2todr_req_valid`  in  1  demand request present.
- `l2todr_req_retry`  out  1  demand not accepted this cycle.
- `l2todr_req`  in  REQ_W  demand payload.
- `l2todr_pfreq_valid`  in  1  prefetch present.
- `l2todr_pfreq_retry`  out  1  always 0 out of reset; prefetches are never back-pressured.
- `l2todr_pfreq`  in  PF_W  prefetch payload.
- `sched_valid`  out  1  entry presented to the tag pipeline.
- `sched_retry`  in  1  tag pipeline refuses the entry this cycle.
- `sched_is_pf`  out  1  presented entry is a prefetch.
- `sched_req`  out  REQ_W  demand queue head; valid when `!sched_is_pf`.
- `sched_pfreq`  out  PF_W  prefetch queue head; valid when `sched_is_pf`.
- `pf_drop`  out  1  one-cycle pulse, a prefetch was dropped.
- `pf_drop_cnt`  out  16  saturating count of dropped prefetches.

## Operation
Transfers:
- A transfer occurs on any port when valid=1 and retry=0 in the same cycle.
- `l2todr_req_retry` equals the registered demand-full flag.
  - There is no same-cycle bypass. A full queue retries even if it dequeues in that cycle.

Queues:
- Each queue is a circular FIFO with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
- Each queue keeps a count of log2(DEPTH)+1 bits.

Arbitration, evaluated when no entry is locked:
- Demand queue empty, prefetch queue non-empty: select prefetch.
- Demand queue non-empty, prefetch queue empty: select demand.
- Both non-empty: select prefetch if `starve_cnt == PF_STARVE`, otherwise select demand.
- Both empty: `sched_valid` = 0.

Lock:
- When `sched_valid` = 1 and `sched_retry` = 1, the selection is locked.
- While locked, `sched_is_pf` and the presented payload stay unchanged until the entry is accepted.

Starvation counter (`starve_cnt`):
- Increments on each demand grant while the prefetch queue is non-empty.
- Clears on a prefetch grant or when the prefetch queue is empty.
- Saturates at PF_STARVE.

Prefetch queue full, incoming prefetch accepted:
- Head dequeued by the pipeline in the same cycle: normal enqueue, no drop.
- Head not presented, or presented but not locked: drop the oldest. Advance the read pointer, write the new entry, count unchanged.
- Head locked (presented and retried): drop the incoming prefetch instead; the queue is unchanged.
- Any drop: `pf_drop` = 1 the next cycle, and `pf_drop_cnt` increments, saturating at 0xFFFF.

## Timing
- Reset values: `l2todr_req_retry` = 0, `l2todr_pfreq_retry` = 0, `sched_valid` = 0, `sched_is_pf` = 0, `pf_drop` = 0, `pf_drop_cnt` = 0, both queues empty, `starve_cnt` = 0, lock = 0.
- Reset may assert mid-operation. It asynchronously discards all queued and locked entries; there is no flush handshake.
- Latency: an entry enqueued at edge N is presentable (`sched_valid` = 1) in the cycle after edge N. Zero-cycle bypass is not allowed.
- Throughput: one grant per cycle, with simultaneous enqueue and dequeue on each queue.
- Full flags, counts, lock, `starve_cnt` and `pf_drop` are registered. `sched_valid`, `sched_is_pf` and the payloads are combinational from registered state only, never from `sched_retry` or input valids.
- Demand queue becomes full at edge N: `l2todr_req_retry` = 1 from the cycle after edge N until the first cycle after a dequeue edge.

## Test plan
- Single demand enqueued at cycle 0 with `sched_retry` = 0: `sched_valid` = 1 and `sched_is_pf` = 0 at cycle 1 with the same payload; queue empty at cycle 2.
- REQ_DEPTH = 4: push 5 demands back-to-back with `sched_retry` = 1. The 5th sees `l2todr_req_retry` = 1. Holding `sched_retry` keeps `sched_req` equal to demand 0.
- 12 demands and 1 prefetch queued, PF_STARVE = 8, `sched_retry` = 0: grants are 8 demands, then the prefetch, then the remaining 4 demands.
- PF_DEPTH = 4, no grants: push prefetches P0..P5. `pf_drop` pulses twice, `pf_drop_cnt` = 2, and the queue holds P2..P5 in order.
- PF_DEPTH = 4, queue full, prefetch head presented and retried (locked), push P4: P4 dropped, `sched_pfreq` stays P0, `pf_drop_cnt` += 1.
- Reset (`reset` = 0) asserted mid-burst with 3 demands, 2 prefetches and a locked entry: outputs go to reset values immediately; after release, `sched_valid` stays 0 until a new enqueue.
